// File: rtl/sqrt_lut_pkg.sv
// sqrt_lut_pkg: shared widths, pipeline latency and the stage-1 root table for
// the sqrt_lut pipelined integer square-root unit.
// Optional build macro: SQRT_LUT_OUT_REG_EN (adds one output register stage).
package sqrt_lut_pkg;

   localparam int IN_W     = 16;
   localparam int OUT_W    = IN_W / 2;
   localparam int N_STAGES = 3;

`ifdef SQRT_LUT_OUT_REG_EN
   localparam int LATENCY = N_STAGES + 1;
`else
   localparam int LATENCY = N_STAGES;
`endif

   typedef logic [IN_W-1:0]  operand_t;
   typedef logic [OUT_W-1:0] root_t;

   // Root table for the lookup stage: floor(sqrt(hi)) for hi in 0..255.
   // floor(sqrt(x)) >> 4 == floor(sqrt(x >> 8)), so this yields the top
   // four result bits exactly. Constant function, so it folds into a ROM.
   function automatic logic [3:0] root_lut(input logic [7:0] hi);
      logic [3:0] r;
      r = '0;
      for (int i = 1; i < 16; i++) begin
         if (i * i <= int'(hi)) r = 4'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/sqrt_lut_if.sv
// sqrt_lut_if: operand/result streaming bus of the sqrt_lut unit.
// The master drives the operand and its qualifier; the slave (the unit)
// returns the root and its qualifier. No backpressure.
interface sqrt_lut_if;
   import sqrt_lut_pkg::*;

   operand_t sqrt_lut_i;
   logic     val_i;
   root_t    sqrt_lut_o;
   logic     val_o;

   modport master (output sqrt_lut_i, output val_i,
                   input  sqrt_lut_o, input  val_o);

   modport slave  (input  sqrt_lut_i, input  val_i,
                   output sqrt_lut_o, output val_o);

endinterface

// File: rtl/sqrt_lut_stage.sv
// sqrt_lut_stage: one 2-bit restoring refinement stage of the square root.
// Tries bits BIT_HI and BIT_HI-1 of the partial root MSB first, keeping a bit
// when the candidate squared does not exceed x. Root and x are registered.
module sqrt_lut_stage
   import sqrt_lut_pkg::*;
#(
   parameter int BIT_HI = 3
) (
   input  logic     clk,
   input  logic     rst,
   input  operand_t x,
   input  root_t    r,
   output operand_t x_q,
   output root_t    r_q
);

   localparam root_t MASK_HI = root_t'(1) << BIT_HI;
   localparam root_t MASK_LO = root_t'(1) << (BIT_HI - 1);

   // Candidate fits when its square is <= x; roots are <= 255, so the
   // 16-bit product never overflows (255*255 = 65025).
   function automatic logic fits(input root_t c, input operand_t v);
      operand_t sq;
      sq = operand_t'(c) * operand_t'(c);
      return sq <= v;
   endfunction

   root_t c_hi, r_hi, c_lo, r_lo;

   // Refine the two bits of this stage, high bit first.
   always_comb begin
      c_hi = r | MASK_HI;
      r_hi = fits(c_hi, x) ? c_hi : r;
      c_lo = r_hi | MASK_LO;
      r_lo = fits(c_lo, x) ? c_lo : r_hi;
   end

   // Register refined root and pass x on to the next stage.
   // NOTE: state uses non-blocking assignments and an async reset in the
   // sensitivity list, so every stage samples pre-edge values and clears at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q <= '0;
         r_q <= '0;
      end else begin
         x_q <= x;
         r_q <= r_lo;
      end
   end

endmodule

// File: rtl/sqrt_lut.sv
// sqrt_lut: pipelined 16-bit floor square root, one operand per clock.
// Stage 1 looks up the top root nibble from x[15:8]; stages 2 and 3 each
// refine two more bits. Latency 3 edges (4 with SQRT_LUT_OUT_REG_EN defined).
module sqrt_lut
   import sqrt_lut_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   sqrt_lut_if.slave  bus
);

   operand_t            x1, x2, x3_unused;
   root_t               r1, r2, r3;
   logic [N_STAGES-1:0] val_sr;

   // Stage 1: register the operand and the table-derived top root nibble.
   // NOTE: data registers load every cycle independent of val_i; only the
   // valid shift register decides whether a result is meaningful.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x1 <= '0;
         r1 <= '0;
      end else begin
         x1 <= bus.sqrt_lut_i;
         r1 <= {root_lut(bus.sqrt_lut_i[IN_W-1 -: 8]), 4'b0000};
      end
   end

   // Valid qualifier travels in lockstep with the data stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) val_sr <= '0;
      else     val_sr <= {val_sr[N_STAGES-2:0], bus.val_i};
   end

   sqrt_lut_stage #(.BIT_HI(3)) u_stage2 (
      .clk (clk),
      .rst (rst),
      .x   (x1),
      .r   (r1),
      .x_q (x2),
      .r_q (r2)
   );

   // The final stage's x pass-through has no consumer and is trimmed.
   sqrt_lut_stage #(.BIT_HI(1)) u_stage3 (
      .clk (clk),
      .rst (rst),
      .x   (x2),
      .r   (r2),
      .x_q (x3_unused),
      .r_q (r3)
   );

`ifdef SQRT_LUT_OUT_REG_EN
   root_t out_q;
   logic  val_q;

   // Optional retiming register on the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         val_q <= 1'b0;
      end else begin
         out_q <= r3;
         val_q <= val_sr[N_STAGES-1];
      end
   end

   assign bus.sqrt_lut_o = out_q;
   assign bus.val_o      = val_q;
`else
   assign bus.sqrt_lut_o = r3;
   assign bus.val_o      = val_sr[N_STAGES-1];
`endif

endmodule

// File: tb/tb_sqrt_lut.sv
// tb_sqrt_lut: self-checking bench for sqrt_lut. Inputs are driven and
// outputs sampled on the falling clock edge. A delay-line reference tracks
// the expected valid/result for every cycle; directed sequences add explicit
// latency, pattern and reset checks.
module tb_sqrt_lut;
   import sqrt_lut_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sqrt_lut_if bus ();

   sqrt_lut dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] x;
      logic [7:0]  r;
   } vec_t;

   vec_t vecs [9];

   // Reference floor square root by linear search.
   function automatic int isqrt(input int x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference delay line: expected valid and root per pipeline position.
   logic mv [LATENCY];
   int   md [LATENCY];
   bit   mon_en = 1'b0;
   int   out_cnt = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            mv[i] <= 1'b0;
            md[i] <= 0;
         end
      end else begin
         mv[0] <= bus.val_i;
         md[0] <= isqrt(int'(bus.sqrt_lut_i));
         for (int i = 1; i < LATENCY; i++) begin
            mv[i] <= mv[i-1];
            md[i] <= md[i-1];
         end
      end
   end

   // Continuous per-cycle comparison against the reference.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         check("mon_val_o", 32'(bus.val_o), 32'(mv[LATENCY-1]));
         if (mv[LATENCY-1]) check("mon_sqrt_lut_o", 32'(bus.sqrt_lut_o), 32'(md[LATENCY-1]));
         if (bus.val_o === 1'b1) out_cnt++;
      end
   end

   // Pulse one operand and verify val_o stays low until exactly LATENCY
   // falling edges later, when it carries the expected root.
   task automatic pulse_check(input string name, input logic [15:0] x, input logic [7:0] exp);
      @(negedge clk);
      bus.sqrt_lut_i = x;
      bus.val_i      = 1'b1;
      for (int k = 1; k <= LATENCY + 1; k++) begin
         @(negedge clk);
         check({name, "_val"}, 32'(bus.val_o), (k == LATENCY) ? 32'd1 : 32'd0);
         if (k == LATENCY) check({name, "_data"}, 32'(bus.sqrt_lut_o), 32'(exp));
         if (k == 1) begin
            bus.val_i      = 1'b0;
            bus.sqrt_lut_i = 16'($urandom_range(0, 65535));
         end
      end
   endtask

   initial begin
      logic [5:0]  pat;
      logic [15:0] sx [6];
      int          base;

      vecs = '{'{16'd0,     8'd0},   '{16'd1,     8'd1},   '{16'd3,     8'd1},
               '{16'd4,     8'd2},   '{16'd255,   8'd15},  '{16'd256,   8'd16},
               '{16'd65024, 8'd254}, '{16'd65025, 8'd255}, '{16'd65535, 8'd255}};

      bus.sqrt_lut_i = '0;
      bus.val_i      = 1'b0;

      // Reset state.
      #1 rst = 1'b1;
      #1;
      check("reset_val_o", 32'(bus.val_o), 32'd0);
      check("reset_sqrt_lut_o", 32'(bus.sqrt_lut_o), 32'd0);
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Corner values with single-cycle pulses.
      for (int i = 0; i < 9; i++) pulse_check("corner", vecs[i].x, vecs[i].r);

      // Back-to-back random stream.
      base = out_cnt;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         bus.sqrt_lut_i = 16'($urandom_range(0, 65535));
         bus.val_i      = 1'b1;
      end
      @(negedge clk);
      bus.val_i = 1'b0;
      repeat (LATENCY + 1) @(negedge clk);
      check("stream_count", 32'(out_cnt - base), 32'd1024);

      // Sparse pattern 1,0,0,1,1,0 with garbage data in idle cycles.
      pat = 6'b011001;  // bit j is the valid for cycle j
      for (int j = 0; j < 6 + LATENCY + 2; j++) begin
         @(negedge clk);
         if (j >= LATENCY && j - LATENCY < 6) begin
            check("sparse_val", 32'(bus.val_o), 32'(pat[j-LATENCY]));
            if (pat[j-LATENCY])
               check("sparse_data", 32'(bus.sqrt_lut_o), 32'(isqrt(int'(sx[j-LATENCY]))));
         end else begin
            check("sparse_val_idle", 32'(bus.val_o), 32'd0);
         end
         if (j < 6) begin
            sx[j]          = 16'($urandom_range(0, 65535));
            bus.sqrt_lut_i = sx[j];
            bus.val_i      = pat[j];
         end else begin
            bus.val_i      = 1'b0;
         end
      end

      // Exhaustive sweep.
      base = out_cnt;
      for (int x = 0; x < 65536; x++) begin
         @(negedge clk);
         bus.sqrt_lut_i = 16'(x);
         bus.val_i      = 1'b1;
      end
      @(negedge clk);
      bus.val_i = 1'b0;
      repeat (LATENCY + 1) @(negedge clk);
      check("sweep_count", 32'(out_cnt - base), 32'd65536);

      // Reset with three operands in flight.
      @(negedge clk);
      bus.sqrt_lut_i = 16'd100; bus.val_i = 1'b1;
      @(negedge clk);
      bus.sqrt_lut_i = 16'd200;
      @(negedge clk);
      bus.sqrt_lut_i = 16'd300;
      @(negedge clk);
      bus.val_i = 1'b0;
      if (LATENCY == 3) check("inflight_first", 32'(bus.sqrt_lut_o), 32'd10);
      #2 rst = 1'b1;
      #1;
      check("midreset_val_o", 32'(bus.val_o), 32'd0);
      check("midreset_sqrt_lut_o", 32'(bus.sqrt_lut_o), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulse_check("post_reset", 16'd50625, 8'd225);
      repeat (LATENCY + 2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
